alu_muldiv_seq: RTL and testbench
=================================

ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, operand and result width in bits (legal 8..64, even).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port reset_n  input  1  reset, synchronous and active-low (one clock; polarity and synchronicity fixed).
REQ-004 The block SHALL have port in_valid  input  1  request carries a valid operation.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 The block SHALL have port ALUoperation  input  4  operation code (REQ-012).
REQ-007 The block SHALL have ports A, B  input  WIDTH  operands.
REQ-008 The block SHALL have port out_valid  output  1  ALUresult/Zero/DivByZero valid.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 The block SHALL have port ALUresult  output  WIDTH  registered result.
REQ-011 The block SHALL have ports Zero, DivByZero  output  1  ALUresult==0; last UDIV had B==0.

Function
REQ-012 Opcodes SHALL be: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 pass B, 12 NOR, 8 MUL (low WIDTH bits of unsigned product), 9 UDIV (unsigned quotient); any other code yields result 0.
REQ-013 The block SHALL implement states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 A request SHALL be accepted when in_valid && in_ready at a rising edge; A, B, ALUoperation captured internally at that edge.
REQ-015 Single-cycle ops (0,1,2,6,7,12, undefined) and UDIV with B==0 SHALL go IDLE->DONE; out_valid asserted the cycle after acceptance (latency 1).
REQ-016 MUL and UDIV with B!=0 SHALL go IDLE->BUSY, iterate one bit per cycle for exactly WIDTH cycles (shift-add multiply, restoring divide), then BUSY->DONE; out_valid asserted WIDTH+1 cycles after acceptance.
REQ-017 The iteration counter SHALL be $clog2(WIDTH)+1 bits, loaded at acceptance, and its terminal value SHALL cause BUSY->DONE.
REQ-018 ADD, SUB, MUL SHALL wrap modulo 2^WIDTH; no carry/overflow output.
REQ-019 UDIV with B==0 SHALL return all-ones and set DivByZero=1; every other completed op SHALL set DivByZero=0.
REQ-020 Zero SHALL be derived from the ALUresult register and is meaningful only while out_valid=1.
REQ-021 In DONE, ALUresult, Zero, DivByZero, out_valid SHALL hold stable until out_valid && out_ready; then DONE->IDLE, out_valid=0 next cycle.
REQ-022 in_valid, A, B, ALUoperation changes during BUSY or DONE SHALL be ignored; no request accepted in the cycle a result is consumed.
REQ-023 ALUresult SHALL only update on DONE entry; intermediate iteration values SHALL not be visible.

Reset
REQ-024 With reset_n=0 at a rising edge, state SHALL become IDLE, out_valid=0, ALUresult=0, DivByZero=0, counter=0; in_ready=1 the following cycle.
REQ-025 Reset during BUSY or DONE SHALL abort the operation with no result ever presented.
REQ-026 Reset SHALL take priority over acceptance and completion in the same cycle.

Verification
REQ-027 WIDTH=64: ADD A=0xFFFF_FFFF_FFFF_FFFF, B=1, out_ready=1 -> out_valid one cycle later, ALUresult=0, Zero=1.
REQ-028 WIDTH=64: MUL A=0x1_0000_0001, B=3 -> out_valid exactly 65 cycles after accept, ALUresult=0x3_0000_0003, in_ready=0 throughout.
REQ-029 WIDTH=8: UDIV A=200, B=7 -> ALUresult=28 after 9 cycles; UDIV A=5, B=0 -> ALUresult=0xFF, DivByZero=1, latency 1.
REQ-030 Backpressure: SUB A=5, B=5 with out_ready=0 for 10 cycles -> ALUresult=0, Zero=1 held stable, in_ready=0; release -> IDLE next cycle.
REQ-031 Reset mid-MUL (cycle 20 of 64) -> out_valid never asserted for that op, in_ready=1 next cycle, following NOR A=0, B=0 returns all-ones.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// alu_muldiv_seq : valid/ready ALU, sequential shift-add MUL and restoring UDIV
// Revision 1.0
// ============================================================================
module alu_muldiv_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUoperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUresult,
  output logic             Zero,
  output logic             DivByZero
);

  localparam int         CNT_W   = $clog2(WIDTH) + 1;
  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_PASS = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_UDIV = 4'd9;
  localparam logic [3:0] OP_NOR  = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             is_div;
  // opnd: multiplicand (shifts left) or divisor (fixed)
  // shreg: multiplier (shifts right) or dividend turning into quotient
  // acc: partial product or partial remainder
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] acc;

  logic [WIDTH-1:0] quick_result;
  logic             quick_dbz;
  logic             start_iter;

  logic [WIDTH-1:0] mul_acc_next;
  logic [WIDTH:0]   div_rem_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_qbit;
  logic [WIDTH-1:0] div_acc_next;
  logic [WIDTH-1:0] div_shreg_next;

  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] opnd_next;
  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] iter_result;

  always_comb begin
    quick_result = '0;
    quick_dbz    = 1'b0;
    start_iter   = 1'b0;
    case (ALUoperation)
      OP_AND:  quick_result = A & B;
      OP_OR:   quick_result = A | B;
      OP_ADD:  quick_result = A + B;
      OP_SUB:  quick_result = A - B;
      OP_PASS: quick_result = B;
      OP_NOR:  quick_result = ~(A | B);
      OP_MUL:  start_iter   = 1'b1;
      OP_UDIV: begin
        if (B == '0) begin
          quick_result = '1;
          quick_dbz    = 1'b1;
        end else begin
          start_iter   = 1'b1;
        end
      end
      default: quick_result = '0;
    endcase
  end

  always_comb begin
    mul_acc_next   = shreg[0] ? (acc + opnd) : acc;

    // Restoring step: bring in the next dividend bit, subtract if it fits.
    div_rem_shift  = {acc, shreg[WIDTH-1]};
    div_trial      = div_rem_shift - {1'b0, opnd};
    div_qbit       = ~div_trial[WIDTH];
    div_acc_next   = div_qbit ? div_trial[WIDTH-1:0] : div_rem_shift[WIDTH-1:0];
    div_shreg_next = {shreg[WIDTH-2:0], div_qbit};

    acc_next       = is_div ? div_acc_next   : mul_acc_next;
    opnd_next      = is_div ? opnd           : (opnd << 1);
    shreg_next     = is_div ? div_shreg_next : (shreg >> 1);
    iter_result    = is_div ? div_shreg_next : mul_acc_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      count     <= '0;
      is_div    <= 1'b0;
      opnd      <= '0;
      shreg     <= '0;
      acc       <= '0;
      ALUresult <= '0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (start_iter) begin
              state  <= BUSY;
              count  <= CNT_W'(WIDTH);
              is_div <= (ALUoperation == OP_UDIV);
              acc    <= '0;
              if (ALUoperation == OP_UDIV) begin
                opnd  <= B;
                shreg <= A;
              end else begin
                opnd  <= A;
                shreg <= B;
              end
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              ALUresult <= quick_result;
              DivByZero <= quick_dbz;
            end
          end
        end
        BUSY: begin
          acc   <= acc_next;
          opnd  <= opnd_next;
          shreg <= shreg_next;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            ALUresult <= iter_result;
            DivByZero <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign Zero = (ALUresult == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// tb_alu_muldiv_seq : randomized self-checking bench, WIDTH=64 and WIDTH=8
// Revision 1.0
// ============================================================================
module tb_alu_muldiv_seq;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  logic        in_valid64, in_ready64, out_valid64, out_ready64, zero64, dbz64;
  logic [3:0]  op64;
  logic [63:0] a64, b64, res64;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8, dbz8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, res8;

  alu_muldiv_seq #(.WIDTH(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid64), .in_ready(in_ready64),
    .ALUoperation(op64), .A(a64), .B(b64), .out_valid(out_valid64),
    .out_ready(out_ready64), .ALUresult(res64), .Zero(zero64), .DivByZero(dbz64));

  alu_muldiv_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .ALUoperation(op8), .A(a8), .B(b8), .out_valid(out_valid8),
    .out_ready(out_ready8), .ALUresult(res8), .Zero(zero8), .DivByZero(dbz8));

  // Reference: plain arithmetic, returns {DivByZero, result}
  function automatic logic [64:0] model(input logic [3:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input int w);
    logic [63:0] mask;
    logic [63:0] r;
    logic        dz;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    dz   = 1'b0;
    case (op)
      4'd0:    r = a & b;
      4'd1:    r = a | b;
      4'd2:    r = a + b;
      4'd6:    r = a - b;
      4'd7:    r = b;
      4'd12:   r = ~(a | b);
      4'd8:    r = a * b;
      4'd9:    if (b == 64'd0) begin r = mask; dz = 1'b1; end else r = a / b;
      default: r = 64'd0;
    endcase
    return {dz, r & mask};
  endfunction

  function automatic int model_latency(input logic [3:0] op, input logic [63:0] b, input int w);
    if (op == 4'd8 || (op == 4'd9 && b != 64'd0)) return w + 1;
    return 1;
  endfunction

  task automatic run_op64(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input int hold, input string name);
    logic [64:0] m;
    int          lat;
    int          exp_lat;
    m       = model(op, a, b, 64);
    exp_lat = model_latency(op, b, 64);
    checks++;
    if (in_ready64 !== 1'b1) begin
      errors++; $display("FAIL %s ready_before_accept: got %b want 1", name, in_ready64);
    end
    op64 = op; a64 = a; b64 = b; in_valid64 = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (out_valid64 !== 1'b1 && lat < 200) begin
      checks++;
      if (in_ready64 !== 1'b0) begin
        errors++; $display("FAIL %s ready_while_busy: got %b want 0 (cycle %0d)", name, in_ready64, lat);
      end
      in_valid64 = 1'($urandom); op64 = 4'($urandom); a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (res64 !== m[63:0] || zero64 !== (m[63:0] == 64'd0) || dbz64 !== m[64] || in_ready64 !== 1'b0) begin
      errors++; $display("FAIL %s result: got res=%h z=%b dbz=%b rdy=%b want res=%h z=%b dbz=%b rdy=0",
                         name, res64, zero64, dbz64, in_ready64, m[63:0], (m[63:0] == 64'd0), m[64]);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid64 = 1'($urandom); op64 = 4'($urandom); a64 = {$urandom, $urandom};
      @(posedge clk); #1;
      checks++;
      if (out_valid64 !== 1'b1 || res64 !== m[63:0] || zero64 !== (m[63:0] == 64'd0) ||
          dbz64 !== m[64] || in_ready64 !== 1'b0) begin
        errors++; $display("FAIL %s hold: got v=%b res=%h z=%b dbz=%b rdy=%b want v=1 res=%h rdy=0",
                           name, out_valid64, res64, zero64, dbz64, in_ready64, m[63:0]);
      end
    end
    // Consume with a request pending; it must not be taken in this cycle.
    out_ready64 = 1'b1; in_valid64 = 1'b1;
    @(posedge clk); #1;
    out_ready64 = 1'b0; in_valid64 = 1'b0;
    checks++;
    if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin
      errors++; $display("FAIL %s release: got v=%b rdy=%b want v=0 rdy=1", name, out_valid64, in_ready64);
    end
  endtask

  task automatic run_op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int hold, input string name);
    logic [64:0] m;
    int          lat;
    int          exp_lat;
    m       = model(op, {56'd0, a}, {56'd0, b}, 8);
    exp_lat = model_latency(op, {56'd0, b}, 8);
    checks++;
    if (in_ready8 !== 1'b1) begin
      errors++; $display("FAIL %s ready_before_accept: got %b want 1", name, in_ready8);
    end
    op8 = op; a8 = a; b8 = b; in_valid8 = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (out_valid8 !== 1'b1 && lat < 50) begin
      checks++;
      if (in_ready8 !== 1'b0) begin
        errors++; $display("FAIL %s ready_while_busy: got %b want 0 (cycle %0d)", name, in_ready8, lat);
      end
      in_valid8 = 1'($urandom); op8 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (res8 !== m[7:0] || zero8 !== (m[7:0] == 8'd0) || dbz8 !== m[64]) begin
      errors++; $display("FAIL %s result: got res=%h z=%b dbz=%b want res=%h z=%b dbz=%b",
                         name, res8, zero8, dbz8, m[7:0], (m[7:0] == 8'd0), m[64]);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid8 = 1'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid8 !== 1'b1 || res8 !== m[7:0] || dbz8 !== m[64] || in_ready8 !== 1'b0) begin
        errors++; $display("FAIL %s hold: got v=%b res=%h dbz=%b rdy=%b want v=1 res=%h rdy=0",
                           name, out_valid8, res8, dbz8, in_ready8, m[7:0]);
      end
    end
    out_ready8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0; in_valid8 = 1'b0;
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      errors++; $display("FAIL %s release: got v=%b rdy=%b want v=0 rdy=1", name, out_valid8, in_ready8);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid64 = 1'b1; op64 = 4'd2; a64 = 64'd1; b64 = 64'd1; out_ready64 = 1'b0;
    in_valid8  = 1'b1; op8  = 4'd2; a8  = 8'd1;  b8  = 8'd1;  out_ready8  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || res64 !== 64'd0 || dbz64 !== 1'b0) begin
      errors++; $display("FAIL reset64: got v=%b rdy=%b res=%h dbz=%b want 0 1 0 0", out_valid64, in_ready64, res64, dbz64);
    end
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || res8 !== 8'd0 || dbz8 !== 1'b0) begin
      errors++; $display("FAIL reset8: got v=%b rdy=%b res=%h dbz=%b want 0 1 0 0", out_valid8, in_ready8, res8, dbz8);
    end
    in_valid64 = 1'b0; in_valid8 = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_wrap();
    run_op64(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, "add_wrap");
  endtask

  task automatic test_mul_long();
    run_op64(4'd8, 64'h1_0000_0001, 64'd3, 2, "mul_long");
  endtask

  task automatic test_div8();
    run_op8(4'd9, 8'd200, 8'd7, 1, "udiv_200_7");
    run_op8(4'd9, 8'd5, 8'd0, 1, "udiv_by_zero");
    run_op8(4'd9, 8'd3, 8'd200, 0, "udiv_small");
    // A follow-up op must clear DivByZero; a div-by-zero result must clear on reset.
    run_op8(4'd9, 8'd9, 8'd0, 0, "udiv_by_zero2");
    run_op8(4'd8, 8'd255, 8'd255, 0, "mul8_wrap");
    run_op8(4'd9, 8'd1, 8'd0, 0, "udiv_by_zero3");
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    checks++;
    if (res8 !== 8'd0 || dbz8 !== 1'b0 || in_ready8 !== 1'b1) begin
      errors++; $display("FAIL reset_clears_dbz: got res=%h dbz=%b rdy=%b want 0 0 1", res8, dbz8, in_ready8);
    end
  endtask

  task automatic test_backpressure();
    run_op64(4'd6, 64'd5, 64'd5, 10, "sub_backpressure");
  endtask

  task automatic test_reset_mid_mul();
    bit seen;
    op64 = 4'd8; a64 = 64'h1234_5678_9ABC_DEF0; b64 = 64'hFFFF_0000_FFFF_0000; in_valid64 = 1'b1;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    checks++;
    if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin
      errors++; $display("FAIL abort_mul: got v=%b rdy=%b want v=0 rdy=1", out_valid64, in_ready64);
    end
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid64 === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL aborted_result_seen: got out_valid=1 want never");
    end
    run_op64(4'd12, 64'd0, 64'd0, 0, "nor_after_abort");
  endtask

  task automatic test_random64();
    logic [3:0] ops [12] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd8, 4'd9, 4'd9, 4'd3, 4'd10, 4'd15};
    logic [63:0] b;
    for (int n = 0; n < 24; n++) begin
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = 64'd0;
      else if ($urandom_range(0, 2) == 0) b = 64'($urandom);
      run_op64(ops[$urandom_range(0, 11)], {$urandom, $urandom}, b, $urandom_range(0, 3), "rand64");
    end
  endtask

  task automatic test_random8();
    logic [3:0] ops [12] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd8, 4'd9, 4'd9, 4'd4, 4'd11, 4'd14};
    logic [7:0] b;
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 4) == 0) b = 8'd0;
      run_op8(ops[$urandom_range(0, 11)], 8'($urandom), b, $urandom_range(0, 2), "rand8");
    end
  endtask

  task automatic test_back_to_back();
    run_op64(4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, "b2b_mul");
    run_op64(4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 0, "b2b_div");
    run_op64(4'd7, 64'd1, 64'hDEAD_BEEF_0000_0001, 0, "b2b_pass");
    run_op64(4'd9, 64'd7, 64'd0, 0, "b2b_div0");
    run_op64(4'd1, 64'd0, 64'd0, 0, "b2b_or_zero");
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_mul_long();
    test_div8();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    test_random64();
    test_random8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
